// File: rtl/ddr_pll_seq_ctrl.sv
// DDR PLL power-up / relock sequencer.
// Holds the PLL in reset, qualifies a synchronised lock, staggers ENCLK2 then
// ENCLK0, and releases the DDR-domain reset only after both clocks are stable.
module ddr_pll_seq_ctrl #(
  parameter int unsigned RST_CYCLES   = 64,
  parameter int unsigned LOCK_TIMEOUT = 65536,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned EN_GAP       = 16,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned RETRY_W      = 2
) (
  input  logic               clkin,
  input  logic               reset,
  input  logic               pll_lock,
  input  logic               restart,
  output logic               pll_reset,
  output logic               pll_enclk0,
  output logic               pll_enclk2,
  output logic               ddr_rst,
  output logic               ready,
  output logic               fail,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_cnt
);

  localparam int unsigned MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_B   = (LOCK_STABLE > EN_GAP) ? LOCK_STABLE : EN_GAP;
  localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_PLL_RST, S_WAIT_LOCK, S_STABLE, S_EN2, S_EN0, S_RUN, S_FAIL
  } state_t;

  state_t             r_state, w_state_nx;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nx;
  logic [RETRY_W-1:0] r_retry, w_retry_nx;
  logic               r_sync1, r_lock_s;
  logic               w_cnt_clr, w_lost_nx;
  logic               w_pll_reset_nx, w_en0_nx, w_en2_nx, w_ddr_rst_nx;
  logic               w_ready_nx, w_fail_nx;

  // Two-flop synchroniser for the asynchronous PLL lock
  always_ff @(posedge clkin) begin
    if (reset) begin
      r_sync1  <= 1'b0;
      r_lock_s <= 1'b0;
    end else begin
      r_sync1  <= pll_lock;
      r_lock_s <= r_sync1;
    end
  end

  // Next state, counter, retry count and registered-output values
  always_comb begin
    w_state_nx = r_state;
    w_retry_nx = r_retry;
    w_cnt_clr  = 1'b0;
    w_lost_nx  = 1'b0;
    if (restart) begin
      // Restart also clears the counter when already in PLL_RST (no state change)
      w_state_nx = S_PLL_RST;
      w_retry_nx = '0;
      w_cnt_clr  = 1'b1;
    end else begin
      unique case (r_state)
        S_PLL_RST: begin
          if (r_cnt == CNT_W'(RST_CYCLES - 1)) w_state_nx = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (r_lock_s) begin
            w_state_nx = S_STABLE;
          end else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
            if (r_retry == RETRY_W'(MAX_RETRY)) begin
              w_state_nx = S_FAIL;
            end else begin
              w_state_nx = S_PLL_RST;
              w_retry_nx = r_retry + 1'b1;
            end
          end
        end
        S_STABLE: begin
          if (!r_lock_s)                              w_state_nx = S_WAIT_LOCK;
          else if (r_cnt == CNT_W'(LOCK_STABLE - 1))  w_state_nx = S_EN2;
        end
        S_EN2, S_EN0, S_RUN: begin
          if (!r_lock_s) begin
            w_state_nx = S_PLL_RST;
            w_lost_nx  = 1'b1;
          end else if (r_state == S_EN2 && r_cnt == CNT_W'(EN_GAP - 1)) begin
            w_state_nx = S_EN0;
          end else if (r_state == S_EN0 && r_cnt == CNT_W'(EN_GAP - 1)) begin
            w_state_nx = S_RUN;
          end
        end
        S_FAIL: w_state_nx = S_FAIL;
        default: w_state_nx = S_PLL_RST;
      endcase
    end

    if (w_cnt_clr || (w_state_nx != r_state)) w_cnt_nx = '0;
    else if (r_cnt == CNT_W'(CNT_MAX))        w_cnt_nx = r_cnt;
    else                                      w_cnt_nx = r_cnt + 1'b1;

    w_pll_reset_nx = (w_state_nx == S_PLL_RST) || (w_state_nx == S_FAIL);
    w_en2_nx       = (w_state_nx == S_EN2) || (w_state_nx == S_EN0) || (w_state_nx == S_RUN);
    w_en0_nx       = (w_state_nx == S_EN0) || (w_state_nx == S_RUN);
    w_ddr_rst_nx   = (w_state_nx != S_RUN);
    w_ready_nx     = (w_state_nx == S_RUN);
    w_fail_nx      = (w_state_nx == S_FAIL);
  end

  // State, counter and output registers
  always_ff @(posedge clkin) begin
    if (reset) begin
      r_state    <= S_PLL_RST;
      r_cnt      <= '0;
      r_retry    <= '0;
      pll_reset  <= 1'b1;
      pll_enclk0 <= 1'b0;
      pll_enclk2 <= 1'b0;
      ddr_rst    <= 1'b1;
      ready      <= 1'b0;
      fail       <= 1'b0;
      lock_lost  <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_retry    <= w_retry_nx;
      pll_reset  <= w_pll_reset_nx;
      pll_enclk0 <= w_en0_nx;
      pll_enclk2 <= w_en2_nx;
      ddr_rst    <= w_ddr_rst_nx;
      ready      <= w_ready_nx;
      fail       <= w_fail_nx;
      lock_lost  <= w_lost_nx;
    end
  end

  assign retry_cnt = r_retry;

endmodule

// File: tb/tb_ddr_pll_seq_ctrl.sv
// Bench for ddr_pll_seq_ctrl: directed bring-up/failure scenarios followed by
// randomized lock/restart/reset traffic, all checked against a timeline model.
module tb_ddr_pll_seq_ctrl;

  localparam int RC  = 4;
  localparam int TO  = 32;
  localparam int LS  = 8;
  localparam int GAP = 2;
  localparam int MR  = 2;

  logic       clk = 1'b0;
  logic       rst, lk, rs;
  logic       pll_reset, pll_enclk0, pll_enclk2, ddr_rst, ready, fail, lock_lost;
  logic [1:0] retry_cnt;
  logic [8:0] obs;

  always #5 clk = ~clk;

  ddr_pll_seq_ctrl #(
    .RST_CYCLES(RC), .LOCK_TIMEOUT(TO), .LOCK_STABLE(LS),
    .EN_GAP(GAP), .MAX_RETRY(MR), .RETRY_W(2)
  ) dut (
    .clkin(clk), .reset(rst), .pll_lock(lk), .restart(rs),
    .pll_reset(pll_reset), .pll_enclk0(pll_enclk0), .pll_enclk2(pll_enclk2),
    .ddr_rst(ddr_rst), .ready(ready), .fail(fail), .lock_lost(lock_lost),
    .retry_cnt(retry_cnt)
  );

  assign obs = {pll_reset, pll_enclk0, pll_enclk2, ddr_rst, ready, fail, lock_lost, retry_cnt};

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Timeline model: phase name plus the edge at which it was entered.
  localparam int PH_RST = 0, PH_WAIT = 1, PH_STAB = 2, PH_E2 = 3, PH_E0 = 4,
                 PH_RUN = 5, PH_FAIL = 6;
  int ph, t0, cyc, retries, since;
  bit lost, h0, h1;

  task automatic go(input int p);
    ph = p;
    t0 = cyc;
  endtask

  task automatic model_edge();
    bit ls;
    int el;
    cyc++;
    if (rst) begin
      go(PH_RST); retries = 0; lost = 0; h0 = 0; h1 = 0; since = 0;
    end else begin
      ls = h1; h1 = h0; h0 = lk;
      el = cyc - t0;
      lost = 0;
      since++;
      if (rs) begin
        go(PH_RST); retries = 0;
      end else begin
        case (ph)
          PH_RST:  if (el == RC) go(PH_WAIT);
          PH_WAIT: if (ls) go(PH_STAB);
                   else if (el == TO) begin
                     if (retries == MR) go(PH_FAIL);
                     else begin retries++; go(PH_RST); end
                   end
          PH_STAB: if (!ls) go(PH_WAIT); else if (el == LS) go(PH_E2);
          PH_E2, PH_E0, PH_RUN:
                   if (!ls) begin go(PH_RST); lost = 1; end
                   else if (ph == PH_E2 && el == GAP) go(PH_E0);
                   else if (ph == PH_E0 && el == GAP) go(PH_RUN);
          default: ;
        endcase
      end
    end
  endtask

  function automatic logic [8:0] model_outs();
    logic [1:0] r;
    r = retries[1:0];
    return {ph == PH_RST || ph == PH_FAIL,
            ph == PH_E0 || ph == PH_RUN,
            ph == PH_E2 || ph == PH_E0 || ph == PH_RUN,
            ph != PH_RUN, ph == PH_RUN, ph == PH_FAIL, lost, r};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("outs", {23'd0, obs}, {23'd0, model_outs()});
  endtask

  int fall_prst, rise_e2, rise_e0, rise_rdy, first_fail, n_lost;

  initial begin
    cyc = 0; ph = PH_RST; t0 = 0; retries = 0; lost = 0; h0 = 0; h1 = 0; since = 0;
    rst = 1; lk = 1; rs = 0;

    // Clean bring-up with lock present from the start
    repeat (3) step();
    check("rst_vals", {23'd0, obs}, 32'h120);
    rst = 0;
    fall_prst = -1; rise_e2 = -1; rise_e0 = -1; rise_rdy = -1;
    repeat (30) begin
      step();
      if (!pll_reset && fall_prst < 0) fall_prst = since;
      if (pll_enclk2 && rise_e2 < 0)   rise_e2 = since;
      if (pll_enclk0 && rise_e0 < 0)   rise_e0 = since;
      if (ready && rise_rdy < 0)       rise_rdy = since;
    end
    check("prst_len", fall_prst, RC);
    check("en2_rise", rise_e2, RC + 1 + LS);
    check("en0_rise", rise_e0, RC + 1 + LS + GAP);
    check("rdy_rise", rise_rdy, RC + 1 + LS + 2 * GAP);

    // No lock at all: three attempts then FAIL
    rst = 1; lk = 0;
    repeat (3) step();
    rst = 0;
    first_fail = -1;
    repeat (120) begin
      step();
      if (fail && first_fail < 0) first_fail = since;
    end
    check("fail_cyc", first_fail, 3 * (RC + TO));
    check("fail_retry", retry_cnt, MR);
    check("fail_hold", fail, 1);

    // Restart from FAIL with lock present
    lk = 1; rs = 1; step(); rs = 0;
    check("rs_fail_clr", fail, 0);
    check("rs_retry_clr", retry_cnt, 0);
    repeat (30) step();
    check("relock_ready", ready, 1);

    // One-cycle lock drop while running
    lk = 0; step(); lk = 1;
    n_lost = 0;
    repeat (30) begin step(); if (lock_lost) n_lost++; end
    check("lost_pulses", n_lost, 1);
    check("lost_retry", retry_cnt, 0);
    check("lost_rerun", ready, 1);

    // Glitch mid-STABLE: no lock_lost, bring-up restarts its qualification
    rs = 1; step(); rs = 0;
    repeat (8) step();
    lk = 0; step(); lk = 1;
    n_lost = 0;
    repeat (40) begin step(); if (lock_lost) n_lost++; end
    check("glitch_nolost", n_lost, 0);
    check("glitch_ready", ready, 1);

    // Restart coincident with lock loss seen in RUN
    lk = 0; step(); step();
    rs = 1; step(); rs = 0; lk = 1;
    check("rs_vs_lost", lock_lost, 0);
    check("rs_vs_prst", pll_reset, 1);
    repeat (30) step();

    // Reset in the middle of EN0
    rs = 1; step(); rs = 0;
    repeat (RC + 1 + LS + GAP + 1) step();
    check("in_en0", {pll_enclk0, ready}, 2'b10);
    rst = 1; step();
    check("rst_mid_en0", {23'd0, obs}, 32'h120);
    rst = 0;

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 999) == 0);
      rs  = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) lk = ~lk;
      step();
    end
    rst = 0; rs = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
